// File: rtl/uart_rx_frame.sv
// UART receiver with internal baud divider, mid-bit sampling, false-start
// rejection and per-word parity / framing / break status.
module uart_rx_frame #(
    parameter int unsigned P_SYSTEM_CLK      = 50_000_000,
    parameter int unsigned P_UART_BURD_RATE  = 9600,
    parameter int unsigned P_UART_DATA_WIDTH = 8,
    parameter int unsigned P_UART_CHECK_ON   = 0,
    parameter int unsigned P_UART_STOP_WIDTH = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_uart_rx,
    output logic [P_UART_DATA_WIDTH-1:0] o_uart_rx_data,
    output logic                         o_uart_rx_valid,
    output logic                         o_parity_err,
    output logic                         o_frame_err,
    output logic                         o_break,
    output logic                         o_busy
);

    localparam int unsigned P_BIT_CNT = P_SYSTEM_CLK / P_UART_BURD_RATE;
    localparam int unsigned P_HALF    = P_BIT_CNT / 2;
    localparam int unsigned CntW      = $clog2(P_BIT_CNT);
    // Index counter is shared by data bits and stop bits.
    localparam int unsigned IdxW      = $clog2(P_UART_DATA_WIDTH + 1);

    localparam logic [CntW-1:0] CntBitLast  = CntW'(P_BIT_CNT - 1);
    localparam logic [CntW-1:0] CntHalfLast = CntW'(P_HALF - 1);
    localparam logic [IdxW-1:0] IdxDataLast = IdxW'(P_UART_DATA_WIDTH - 1);
    localparam logic [IdxW-1:0] IdxStopLast = IdxW'(P_UART_STOP_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } state_e;

    // Synchroniser and edge detect.
    logic [1:0] r_rx_sync;
    logic       r_rx_prev;
    logic       rx_s;
    logic       rx_fall;

    state_e                       state_q, state_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic [IdxW-1:0]              idx_q, idx_d;
    logic [P_UART_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                         par_q, par_d;
    logic                         ferr_acc_q, ferr_acc_d;

    logic [P_UART_DATA_WIDTH-1:0] data_q, data_d;
    logic                         valid_q, valid_d;
    logic                         perr_q, perr_d;
    logic                         ferr_q, ferr_d;
    logic                         brk_q, brk_d;

    logic cnt_bit_last;
    logic ferr_now;
    logic par_xor;
    logic perr_calc;

    assign rx_s    = r_rx_sync[1];
    // Previous value resets to 0, so a line held low through reset never
    // looks like a falling edge.
    assign rx_fall = r_rx_prev & ~rx_s;

    assign cnt_bit_last = (cnt_q == CntBitLast);
    assign ferr_now     = ferr_acc_q | ~rx_s;
    assign par_xor      = (^shift_q) ^ par_q;
    assign perr_calc    = (P_UART_CHECK_ON == 1) ? ~par_xor :
                          ((P_UART_CHECK_ON == 2) ? par_xor : 1'b0);

    // Two-flop synchroniser plus previous-value flop for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_sync <= 2'b00;
            r_rx_prev <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], i_uart_rx};
            r_rx_prev <= r_rx_sync[1];
        end
    end

    // FSM state, bit timing, shift register and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    // Next-state logic: every bit after start is sampled at the last count
    // of its bit period, which lands mid-bit because START only waits half.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ferr_acc_d = ferr_acc_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_fall) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalfLast) begin
                    cnt_d      = '0;
                    idx_d      = '0;
                    par_d      = 1'b0;
                    ferr_acc_d = 1'b0;
                    // High at mid start bit is a glitch, not a frame.
                    state_d    = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_bit_last) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[P_UART_DATA_WIDTH-1:1]};
                    if (idx_q == IdxDataLast) begin
                        idx_d   = '0;
                        state_d = (P_UART_CHECK_ON > 0) ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (cnt_bit_last) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_bit_last) begin
                    cnt_d      = '0;
                    ferr_acc_d = ferr_now;
                    if (idx_q == IdxStopLast) begin
                        // Publish the word together with its status flags.
                        state_d = StDone;
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        perr_d  = perr_calc;
                        ferr_d  = ferr_now;
                        brk_d   = (shift_q == '0) && !par_q && ferr_now;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign o_uart_rx_data  = data_q;
    assign o_uart_rx_valid = valid_q;
    assign o_parity_err    = perr_q;
    assign o_frame_err     = ferr_q;
    assign o_break         = brk_q;
    assign o_busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: four instances (8N1, 8O1, 8E1, 8N2) at
// 10 clocks per bit, each on its own RX line.
module tb_uart_rx_frame;

    localparam int unsigned SysClk = 50_000_000;
    localparam int unsigned Baud   = 5_000_000;
    localparam int          BitCyc = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rx_line = 4'hF;

    logic [7:0] rx_data [4];
    logic [3:0] valid;
    logic [3:0] perr;
    logic [3:0] ferr;
    logic [3:0] brk;
    logic [3:0] busy;

    always #5 clk = ~clk;

    uart_rx_frame #(
        .P_SYSTEM_CLK(SysClk), .P_UART_BURD_RATE(Baud), .P_UART_DATA_WIDTH(8),
        .P_UART_CHECK_ON(0), .P_UART_STOP_WIDTH(1)
    ) u_dut_8n1 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_line[0]), .o_uart_rx_data(rx_data[0]),
        .o_uart_rx_valid(valid[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]),
        .o_break(brk[0]), .o_busy(busy[0])
    );

    uart_rx_frame #(
        .P_SYSTEM_CLK(SysClk), .P_UART_BURD_RATE(Baud), .P_UART_DATA_WIDTH(8),
        .P_UART_CHECK_ON(1), .P_UART_STOP_WIDTH(1)
    ) u_dut_8o1 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_line[1]), .o_uart_rx_data(rx_data[1]),
        .o_uart_rx_valid(valid[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]),
        .o_break(brk[1]), .o_busy(busy[1])
    );

    uart_rx_frame #(
        .P_SYSTEM_CLK(SysClk), .P_UART_BURD_RATE(Baud), .P_UART_DATA_WIDTH(8),
        .P_UART_CHECK_ON(2), .P_UART_STOP_WIDTH(1)
    ) u_dut_8e1 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_line[2]), .o_uart_rx_data(rx_data[2]),
        .o_uart_rx_valid(valid[2]), .o_parity_err(perr[2]), .o_frame_err(ferr[2]),
        .o_break(brk[2]), .o_busy(busy[2])
    );

    uart_rx_frame #(
        .P_SYSTEM_CLK(SysClk), .P_UART_BURD_RATE(Baud), .P_UART_DATA_WIDTH(8),
        .P_UART_CHECK_ON(0), .P_UART_STOP_WIDTH(2)
    ) u_dut_8n2 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_line[3]), .o_uart_rx_data(rx_data[3]),
        .o_uart_rx_valid(valid[3]), .o_parity_err(perr[3]), .o_frame_err(ferr[3]),
        .o_break(brk[3]), .o_busy(busy[3])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cyc = 0;

    // Per-channel monitor state, sampled on the falling edge.
    int         vcnt     [4] = '{default: 0};
    int         vcyc     [4] = '{default: 0};
    int         busy_cnt [4] = '{default: 0};
    int         err_cnt  [4] = '{default: 0};
    logic [7:0] vdata    [4] = '{default: 8'h00};
    logic       vperr    [4] = '{default: 1'b0};
    logic       vferr    [4] = '{default: 1'b0};
    logic       vbrk     [4] = '{default: 1'b0};
    logic [7:0] q0[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (busy[i]) busy_cnt[i]++;
            if (valid[i]) begin
                vcnt[i]++;
                vcyc[i]  = cyc;
                vdata[i] = rx_data[i];
                vperr[i] = perr[i];
                vferr[i] = ferr[i];
                vbrk[i]  = brk[i];
                if (perr[i] || ferr[i]) err_cnt[i]++;
                if (i == 0) q0.push_back(rx_data[0]);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bits go out LSB first, each held one bit period; call on a falling edge.
    task automatic send_bits(input int ch, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_line[ch] = bits[i];
            if (i == 0) start_cyc = cyc;
            repeat (BitCyc) @(negedge clk);
        end
    endtask

    task automatic idle(input int ch, input int n);
        rx_line[ch] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_8n1(input int ch, input logic [7:0] d);
        send_bits(ch, 16'({1'b1, d, 1'b0}), 10);
    endtask

    int base_v;
    int base_b;
    int base_e;
    int base_q;
    logic [7:0] byte_v;

    initial begin
        repeat (4) @(negedge clk);
        // Outputs while reset is held.
        check("rst_data",  32'(rx_data[0]), 32'h0);
        check("rst_valid", 32'(valid[0]), 32'h0);
        check("rst_perr",  32'(perr[1]), 32'h0);
        check("rst_ferr",  32'(ferr[0]), 32'h0);
        check("rst_break", 32'(brk[0]), 32'h0);
        check("rst_busy",  32'(busy[0]), 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 8N1 0xA5: E is two cycles after the pin falls, valid at E+96.
        base_v = vcnt[0];
        base_b = busy_cnt[0];
        send_8n1(0, 8'hA5);
        idle(0, 20);
        check("a5_vcnt",    32'(vcnt[0] - base_v), 32'd1);
        check("a5_latency", 32'(vcyc[0] - start_cyc), 32'd98);
        check("a5_data",    32'(vdata[0]), 32'hA5);
        check("a5_perr",    32'(vperr[0]), 32'h0);
        check("a5_ferr",    32'(vferr[0]), 32'h0);
        check("a5_busy",    32'(busy_cnt[0] - base_b), 32'd96);

        // Odd parity, 0x03 has even weight: p=1 good, p=0 bad.
        base_v = vcnt[1];
        send_bits(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11);
        idle(1, 20);
        check("odd_p1_perr", 32'(vperr[1]), 32'h0);
        check("odd_p1_data", 32'(vdata[1]), 32'h03);
        send_bits(1, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11);
        idle(1, 20);
        check("odd_p0_perr", 32'(vperr[1]), 32'h1);
        check("odd_p0_data", 32'(vdata[1]), 32'h03);
        check("odd_vcnt",    32'(vcnt[1] - base_v), 32'd2);

        // Even parity: flags invert.
        send_bits(2, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11);
        idle(2, 20);
        check("even_p1_perr", 32'(vperr[2]), 32'h1);
        send_bits(2, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11);
        idle(2, 20);
        check("even_p0_perr", 32'(vperr[2]), 32'h0);
        check("even_p0_data", 32'(vdata[2]), 32'h03);

        // 8N2 with bad second stop, then a clean frame.
        base_v = vcnt[3];
        send_bits(3, 16'({1'b0, 1'b1, 8'h5A, 1'b0}), 11);
        idle(3, 30);
        check("n2_bad_vcnt",  32'(vcnt[3] - base_v), 32'd1);
        check("n2_bad_data",  32'(vdata[3]), 32'h5A);
        check("n2_bad_ferr",  32'(vferr[3]), 32'h1);
        check("n2_bad_break", 32'(vbrk[3]), 32'h0);
        send_bits(3, 16'({1'b1, 1'b1, 8'h11, 1'b0}), 11);
        idle(3, 20);
        check("n2_good_data", 32'(vdata[3]), 32'h11);
        check("n2_good_ferr", 32'(vferr[3]), 32'h0);

        // Three-cycle glitch is rejected, then a real frame.
        base_v = vcnt[0];
        rx_line[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("glitch_busy", 32'(busy[0]), 32'h0);
        idle(0, 20);
        check("glitch_vcnt", 32'(vcnt[0] - base_v), 32'd0);
        send_8n1(0, 8'h7E);
        idle(0, 20);
        check("post_glitch_data", 32'(vdata[0]), 32'h7E);
        check("post_glitch_vcnt", 32'(vcnt[0] - base_v), 32'd1);

        // Break: 30 bit times low gives exactly one flagged word.
        base_v = vcnt[0];
        rx_line[0] = 1'b0;
        repeat (30 * BitCyc) @(negedge clk);
        check("brk_vcnt",  32'(vcnt[0] - base_v), 32'd1);
        check("brk_data",  32'(vdata[0]), 32'h00);
        check("brk_ferr",  32'(vferr[0]), 32'h1);
        check("brk_flag",  32'(vbrk[0]), 32'h1);
        idle(0, 30);
        check("brk_release_vcnt", 32'(vcnt[0] - base_v), 32'd1);

        // Reset during data bit 3 of 0xC3 (bits 0..2 are 1,1,0).
        base_v = vcnt[0];
        rx_line[0] = 1'b0;
        repeat (BitCyc) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (2 * BitCyc) @(negedge clk);
        rx_line[0] = 1'b0;
        repeat (BitCyc) @(negedge clk);
        rx_line[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy_before_rst", 32'(busy[0]), 32'h1);
        rx_line[0] = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_ferr0",  32'(ferr[0]), 32'h0);
        check("mid_rst_busy0",  32'(busy[0]), 32'h0);
        check("mid_rst_data3",  32'(rx_data[3]), 32'h0);
        check("mid_rst_perr1",  32'(perr[1]), 32'h0);
        check("mid_rst_valid0", 32'(valid[0]), 32'h0);
        rst = 1'b0;
        idle(0, 30);
        check("mid_rst_vcnt", 32'(vcnt[0] - base_v), 32'd0);
        send_8n1(0, 8'hC3);
        idle(0, 20);
        check("post_rst_data", 32'(vdata[0]), 32'hC3);
        check("post_rst_ferr", 32'(vferr[0]), 32'h0);

        // Sixteen back-to-back frames with no idle gap.
        base_v = vcnt[0];
        base_e = err_cnt[0];
        base_q = q0.size();
        for (int i = 0; i < 16; i++) begin
            send_8n1(0, 8'(i));
        end
        idle(0, 30);
        check("b2b_vcnt", 32'(vcnt[0] - base_v), 32'd16);
        check("b2b_errs", 32'(err_cnt[0] - base_e), 32'd0);
        for (int i = 0; i < 16; i++) begin
            byte_v = 8'hFF;
            if (base_q + i < q0.size()) byte_v = q0[base_q + i];
            check($sformatf("b2b_data_%0d", i), 32'(byte_v), 32'(i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
